// File: rtl/uart_alu_ctrl.sv
// Sequencer between UART RX/TX and the ALU: gathers operand A, operand B and
// opcode, runs one ALU exchange, and recovers from timeouts or bad opcodes.
module uart_alu_ctrl #(
    parameter int SIZEDATA       = 8,
    parameter int SIZEOP         = 6,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [SIZEDATA-1:0] i_rx_data,
    input  logic                i_tx_done,
    input  logic [SIZEDATA-1:0] i_alu_result,
    output logic [SIZEDATA-1:0] o_alu_a,
    output logic [SIZEDATA-1:0] o_alu_b,
    output logic [SIZEOP-1:0]   o_alu_op,
    output logic                o_tx_signal,
    output logic [SIZEDATA-1:0] o_tx_result,
    output logic                o_busy,
    output logic                o_error
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        WAIT_TX
    } state_t;

    state_t            state;
    logic              rx_done_q;
    logic              tx_done_q;
    logic [CW-1:0]     tmo_cnt;
    logic              rx_evt;
    logic              tx_evt;
    logic              tmo_hit;
    logic [SIZEOP-1:0] rx_op;

    assign rx_evt  = i_rx_done & ~rx_done_q;
    assign tx_evt  = i_tx_done & ~tx_done_q;
    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign rx_op   = i_rx_data[SIZEOP-1:0];
    assign o_busy  = (state != WAIT_A);

    function automatic logic op_valid(input logic [SIZEOP-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            SIZEOP'(6'b100000), SIZEOP'(6'b100010), SIZEOP'(6'b100100),
            SIZEOP'(6'b100101), SIZEOP'(6'b100110), SIZEOP'(6'b100111),
            SIZEOP'(6'b000011), SIZEOP'(6'b000010): ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= WAIT_A;
            rx_done_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            tmo_cnt     <= '0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_op    <= '0;
            o_tx_signal <= 1'b0;
            o_tx_result <= '0;
            o_error     <= 1'b0;
        end else begin
            rx_done_q   <= i_rx_done;
            tx_done_q   <= i_tx_done;
            o_tx_signal <= 1'b0;
            o_error     <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (rx_evt) begin
                        o_alu_a <= i_rx_data;
                        state   <= WAIT_B;
                        tmo_cnt <= '0;
                    end
                end
                WAIT_B: begin
                    if (rx_evt) begin
                        o_alu_b <= i_rx_data;
                        state   <= WAIT_OP;
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        o_error <= 1'b1;
                        state   <= WAIT_A;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                WAIT_OP: begin
                    // A byte arriving on the final allowed cycle beats the timeout.
                    if (rx_evt) begin
                        if (op_valid(rx_op)) begin
                            o_alu_op <= rx_op;
                            state    <= EXEC;
                        end else begin
                            o_error <= 1'b1;
                            state   <= WAIT_A;
                        end
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        o_error <= 1'b1;
                        state   <= WAIT_A;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                EXEC: begin
                    o_tx_result <= i_alu_result;
                    o_tx_signal <= 1'b1;
                    state       <= WAIT_TX;
                    tmo_cnt     <= '0;
                end
                WAIT_TX: begin
                    if (tx_evt) begin
                        state   <= WAIT_A;
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        o_error <= 1'b1;
                        state   <= WAIT_A;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= WAIT_A;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a small behavioural ALU and
// hand-computed expected values; timeout shortened to 100 cycles.
module tb_uart_alu_ctrl;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic       i_tx_done;
    logic [7:0] i_alu_result;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic       o_tx_signal;
    logic [7:0] o_tx_result;
    logic       o_busy;
    logic       o_error;

    int total = 0;
    int bad   = 0;

    uart_alu_ctrl #(
        .SIZEDATA      (8),
        .SIZEOP        (6),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .i_tx_done   (i_tx_done),
        .i_alu_result(i_alu_result),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .o_tx_signal (o_tx_signal),
        .o_tx_result (o_tx_result),
        .o_busy      (o_busy),
        .o_error     (o_error)
    );

    always #5 i_clock = ~i_clock;

    // Combinational ALU stand-in driven by the latched operands.
    logic signed [7:0] sa;
    always_comb begin
        sa = o_alu_a;
        case (o_alu_op)
            6'b100000: i_alu_result = o_alu_a + o_alu_b;
            6'b100010: i_alu_result = o_alu_a - o_alu_b;
            6'b100100: i_alu_result = o_alu_a & o_alu_b;
            6'b100101: i_alu_result = o_alu_a | o_alu_b;
            6'b100110: i_alu_result = o_alu_a ^ o_alu_b;
            6'b100111: i_alu_result = ~(o_alu_a | o_alu_b);
            6'b000011: i_alu_result = sa >>> o_alu_b;
            6'b000010: i_alu_result = o_alu_a >> o_alu_b;
            default:   i_alu_result = 8'h00;
        endcase
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        tick();
    endtask

    task automatic tx_ack();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00; i_tx_done = 1'b0;
        repeat (3) tick();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
        total++; if (o_tx_signal !== 1'b0) begin bad++; $display("FAIL rst_txsig: got %b expected 0", o_tx_signal); end
        total++; if (o_error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b expected 0", o_error); end
        i_reset = 1'b1;
        tick();
        send_byte(8'h5A);
        total++; if (o_alu_a !== 8'h5A) begin bad++; $display("FAIL pre_rst_a: got %h expected 5a", o_alu_a); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL pre_rst_busy: got %b expected 1", o_busy); end
        i_reset = 1'b0;
        repeat (5) tick();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", o_busy); end
        total++; if ({o_alu_a, o_alu_b, o_alu_op, o_tx_result} !== 30'd0) begin bad++;
            $display("FAIL midrst_data: got a=%h b=%h op=%b res=%h expected all 0", o_alu_a, o_alu_b, o_alu_op, o_tx_result); end
        total++; if ({o_tx_signal, o_error} !== 2'b00) begin bad++; $display("FAIL midrst_pulses: got %b expected 00", {o_tx_signal, o_error}); end
        i_reset = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        send_byte(8'h05);
        send_byte(8'h03);
        i_rx_data = 8'h20; i_rx_done = 1'b1;
        tick();
        total++; if (o_tx_signal !== 1'b0) begin bad++; $display("FAIL nom_txsig_early: got %b expected 0", o_tx_signal); end
        total++; if (o_alu_op !== 6'b100000) begin bad++; $display("FAIL nom_op: got %b expected 100000", o_alu_op); end
        i_rx_done = 1'b0;
        tick();
        total++; if (o_tx_signal !== 1'b1) begin bad++; $display("FAIL nom_txsig: got %b expected 1", o_tx_signal); end
        total++; if (o_tx_result !== 8'h08) begin bad++; $display("FAIL nom_result: got %h expected 08", o_tx_result); end
        total++; if ({o_alu_a, o_alu_b} !== 16'h0503) begin bad++; $display("FAIL nom_operands: got %h expected 0503", {o_alu_a, o_alu_b}); end
        tick();
        total++; if (o_tx_signal !== 1'b0) begin bad++; $display("FAIL nom_txsig_len: got %b expected 0", o_tx_signal); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL nom_busy_wait: got %b expected 1", o_busy); end
        i_tx_done = 1'b1;
        tick();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL nom_busy_fall: got %b expected 0", o_busy); end
        i_tx_done = 1'b0;
        tick();
        total++; if (o_tx_result !== 8'h08) begin bad++; $display("FAIL nom_result_hold: got %h expected 08", o_tx_result); end
    endtask

    task automatic test_level_hold();
        i_rx_data = 8'hAA; i_rx_done = 1'b1;
        repeat (10) tick();
        i_rx_done = 1'b0;
        tick();
        total++; if (o_alu_a !== 8'hAA) begin bad++; $display("FAIL lvl_a: got %h expected aa", o_alu_a); end
        total++; if (o_alu_b !== 8'h03) begin bad++; $display("FAIL lvl_b_kept: got %h expected 03", o_alu_b); end
        // Still in WAIT_B: this byte is operand B, not a (bad) opcode.
        send_byte(8'h06);
        total++; if (o_alu_b !== 8'h06) begin bad++; $display("FAIL lvl_b: got %h expected 06", o_alu_b); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL lvl_busy: got %b expected 1", o_busy); end
        i_rx_data = 8'h22; i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        tick();
        total++; if ({o_tx_signal, o_tx_result} !== 9'h1A4) begin bad++; $display("FAIL lvl_sub: got %b/%h expected 1/a4", o_tx_signal, o_tx_result); end
        tx_ack();
    endtask

    task automatic test_invalid_op();
        logic seen_tx;
        send_byte(8'h01);
        send_byte(8'h02);
        i_rx_data = 8'h3F; i_rx_done = 1'b1;
        tick();
        total++; if (o_error !== 1'b1) begin bad++; $display("FAIL inv_error: got %b expected 1", o_error); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL inv_busy: got %b expected 0", o_busy); end
        total++; if (o_alu_op !== 6'b100010) begin bad++; $display("FAIL inv_op_kept: got %b expected 100010", o_alu_op); end
        i_rx_done = 1'b0;
        seen_tx = 1'b0;
        tick();
        total++; if (o_error !== 1'b0) begin bad++; $display("FAIL inv_error_len: got %b expected 0", o_error); end
        for (int i = 0; i < 4; i++) begin
            if (o_tx_signal) seen_tx = 1'b1;
            tick();
        end
        total++; if (seen_tx !== 1'b0) begin bad++; $display("FAIL inv_no_tx: got %b expected 0", seen_tx); end
    endtask

    task automatic test_timeout();
        logic early;
        send_byte(8'h11);
        early = 1'b0;
        for (int i = 2; i < 100; i++) begin
            tick();
            if (o_error) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b expected 0", early); end
        tick();
        total++; if (o_error !== 1'b1) begin bad++; $display("FAIL tmo_error: got %b expected 1", o_error); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL tmo_busy: got %b expected 0", o_busy); end
        total++; if (o_alu_a !== 8'h11) begin bad++; $display("FAIL tmo_a_kept: got %h expected 11", o_alu_a); end
        tick();
        total++; if (o_error !== 1'b0) begin bad++; $display("FAIL tmo_error_len: got %b expected 0", o_error); end
        send_byte(8'h04);
        send_byte(8'h02);
        i_rx_data = 8'h22; i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        tick();
        total++; if ({o_tx_signal, o_tx_result} !== 9'h102) begin bad++; $display("FAIL tmo_recover: got %b/%h expected 1/02", o_tx_signal, o_tx_result); end
        tx_ack();
    endtask

    task automatic test_boundary();
        logic early;
        send_byte(8'h07);
        send_byte(8'h03);
        early = 1'b0;
        for (int i = 2; i < 100; i++) begin
            tick();
            if (o_error) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL bnd_early: got %b expected 0", early); end
        i_rx_data = 8'h20; i_rx_done = 1'b1;
        tick();
        total++; if (o_error !== 1'b0) begin bad++; $display("FAIL bnd_error: got %b expected 0", o_error); end
        total++; if (o_alu_op !== 6'b100000) begin bad++; $display("FAIL bnd_op: got %b expected 100000", o_alu_op); end
        i_rx_done = 1'b0;
        tick();
        total++; if ({o_tx_signal, o_tx_result} !== 9'h10A) begin bad++; $display("FAIL bnd_add: got %b/%h expected 1/0a", o_tx_signal, o_tx_result); end
        send_byte(8'h55);
        total++; if (o_alu_a !== 8'h07) begin bad++; $display("FAIL bnd_rx_in_tx: got %h expected 07", o_alu_a); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL bnd_busy_tx: got %b expected 1", o_busy); end
        tx_ack();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL bnd_done: got %b expected 0", o_busy); end
    endtask

    task automatic test_back_to_back();
        logic early;
        // Upper received bits ignored: 0xC3 decodes as SRA.
        send_byte(8'h80);
        send_byte(8'h02);
        i_rx_data = 8'hC3; i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        tick();
        total++; if (o_alu_op !== 6'b000011) begin bad++; $display("FAIL b2b_op_mask: got %b expected 000011", o_alu_op); end
        total++; if (o_tx_result !== 8'hE0) begin bad++; $display("FAIL b2b_sra: got %h expected e0", o_tx_result); end
        i_reset = 1'b0;
        tick();
        total++; if ({o_busy, o_tx_result, o_alu_a} !== 17'd0) begin bad++; $display("FAIL b2b_rst_tx: got %b/%h/%h expected 0/00/00", o_busy, o_tx_result, o_alu_a); end
        i_reset = 1'b1;
        tick();
        tx_ack();
        total++; if ({o_busy, o_error} !== 2'b00) begin bad++; $display("FAIL b2b_stale_txdone: got %b expected 00", {o_busy, o_error}); end
        for (int k = 0; k < 2; k++) begin
            send_byte(8'h01);
            send_byte(8'h02);
            i_rx_data = (k == 0) ? 8'h00 : 8'h3F; i_rx_done = 1'b1;
            tick();
            total++; if (o_error !== 1'b1) begin bad++; $display("FAIL b2b_err%0d: got %b expected 1", k, o_error); end
            i_rx_done = 1'b0;
            tick();
            total++; if (o_error !== 1'b0) begin bad++; $display("FAIL b2b_err%0d_len: got %b expected 0", k, o_error); end
        end
        // Frame left waiting for a tx_done that never comes.
        send_byte(8'h09);
        send_byte(8'h01);
        i_rx_data = 8'h26; i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        tick();
        total++; if ({o_tx_signal, o_tx_result} !== 9'h108) begin bad++; $display("FAIL b2b_xor: got %b/%h expected 1/08", o_tx_signal, o_tx_result); end
        early = 1'b0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (o_error) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL txtmo_early: got %b expected 0", early); end
        tick();
        total++; if ({o_error, o_busy} !== 2'b10) begin bad++; $display("FAIL txtmo: got %b expected 10", {o_error, o_busy}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_level_hold();
        test_invalid_op();
        test_timeout();
        test_boundary();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
